// File: rtl/dvi_pkg.sv
// dvi_pkg: shared DVI timing types, mode presets and TMDS control tokens
package dvi_pkg;
  typedef struct packed {
    int active;
    int front;
    int sync;
    int back;
  } timing_t;
  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_t;
  localparam mode_t VGA_640x480  = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
  localparam mode_t SVGA_800x600 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;
  function automatic logic [9:0] tmds_ctrl(input logic c1, input logic c0);
    return c1 ? (c0 ? CTRL_TOKEN_11 : CTRL_TOKEN_10) : (c0 ? CTRL_TOKEN_01 : CTRL_TOKEN_00);
  endfunction
endpackage

// File: rtl/dvi_axis_counter.sv
// dvi_axis_counter: one raster axis position counter with region decode
module dvi_axis_counter
  import dvi_pkg::*;
#(
  parameter int ACTIVE = VGA_640x480.h.active,
  parameter int FRONT  = VGA_640x480.h.front,
  parameter int SYNC   = VGA_640x480.h.sync,
  parameter int BACK   = VGA_640x480.h.back,
  parameter bit POL    = 1'b0,
  parameter int W      = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o,
  output logic         active_o,
  output logic         sync_o
);
  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
  localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FRONT);
  localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FRONT + SYNC);
  if (TOTAL > (1 << W)) begin : g_width_check
    $error("dvi_axis_counter: total %0d does not fit in %0d bits", TOTAL, W);
  end
  logic [W:0] pos;
  assign pos      = {1'b0, cnt_o};
  assign tc_o     = cnt_o == LAST;
  assign active_o = pos < ACT_END;
  assign sync_o   = (pos >= SYNC_BEG && pos < SYNC_END) ? POL : ~POL;
  always_ff @(posedge clk_i)
    if (rst_i) cnt_o <= '0;
    else if (en_i) cnt_o <= tc_o ? '0 : cnt_o + 1'b1;
endmodule

// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen: DVI raster timing with registered DE/HSYNC/VSYNC and pixel strobes
module dvi_timing_gen
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_640x480.h.active,
  parameter int H_FRONT    = VGA_640x480.h.front,
  parameter int H_SYNC     = VGA_640x480.h.sync,
  parameter int H_BACK     = VGA_640x480.h.back,
  parameter int V_ACTIVE   = VGA_640x480.v.active,
  parameter int V_FRONT    = VGA_640x480.v.front,
  parameter int V_SYNC     = VGA_640x480.v.sync,
  parameter int V_BACK     = VGA_640x480.v.back,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int W_X        = 12,
  parameter int W_Y        = 11
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic [W_X-1:0] x_o,
  output logic [W_Y-1:0] y_o,
  output logic           line_start_o,
  output logic           frame_start_o
);
  logic [W_X-1:0] h_cnt;
  logic [W_Y-1:0] v_cnt;
  logic h_tc, h_act, h_sync, v_act, v_sync, unused_v_tc;
  dvi_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_SYNC_POL), .W(W_X)
  ) u_h (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .cnt_o(h_cnt), .tc_o(h_tc), .active_o(h_act), .sync_o(h_sync)
  );
  dvi_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_SYNC_POL), .W(W_Y)
  ) u_v (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i && h_tc),
    .cnt_o(v_cnt), .tc_o(unused_v_tc), .active_o(v_act), .sync_o(v_sync)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      de_o          <= 1'b0;
      hsync_o       <= ~H_SYNC_POL;
      vsync_o       <= ~V_SYNC_POL;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (en_i) begin
      de_o          <= h_act && v_act;
      hsync_o       <= h_sync;
      vsync_o       <= v_sync;
      x_o           <= h_cnt;
      y_o           <= v_cnt;
      line_start_o  <= h_cnt == '0;
      frame_start_o <= h_cnt == '0 && v_cnt == '0;
    end
endmodule

// File: tb/tb_dvi_timing_gen.sv
// tb_dvi_timing_gen: directed checks of dvi_timing_gen at small and default timings
module tb_dvi_timing_gen;
  import dvi_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  always #5 clk = ~clk;
  logic s_de, s_hs, s_vs, s_ls, s_fs;
  logic [2:0] s_x, s_y;
  logic p_de, p_hs, p_vs, p_ls, p_fs;
  logic [2:0] p_x, p_y;
  logic d_de, d_hs, d_vs, d_ls, d_fs;
  logic [11:0] d_x;
  logic [10:0] d_y;
  int n_cmp = 0;
  int n_bad = 0;
  dvi_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .W_X(3), .W_Y(3)
  ) u_sml (
    .clk_i(clk), .rst_i(rst), .en_i(en), .de_o(s_de), .hsync_o(s_hs), .vsync_o(s_vs),
    .x_o(s_x), .y_o(s_y), .line_start_o(s_ls), .frame_start_o(s_fs)
  );
  dvi_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .W_X(3), .W_Y(3)
  ) u_pos (
    .clk_i(clk), .rst_i(rst), .en_i(en), .de_o(p_de), .hsync_o(p_hs), .vsync_o(p_vs),
    .x_o(p_x), .y_o(p_y), .line_start_o(p_ls), .frame_start_o(p_fs)
  );
  dvi_timing_gen u_def (
    .clk_i(clk), .rst_i(rst), .en_i(en), .de_o(d_de), .hsync_o(d_hs), .vsync_o(d_vs),
    .x_o(d_x), .y_o(d_y), .line_start_o(d_ls), .frame_start_o(d_fs)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [9:0] tok(input logic vs, input logic hs);
    case ({vs, hs})
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction
  initial begin
    logic [2:0] eh, ev;
    logic ede, ehs, evs, els, efs;
    int n_de, n_hl, n_ls, n_fs, first_hl;
    step();
    step();
    chk("rst_sml", 32'({s_de, s_hs, s_vs, s_ls, s_fs, s_x, s_y}), 32'(11'b01100_000_000));
    chk("rst_pos", 32'({p_de, p_hs, p_vs, p_ls, p_fs, p_x, p_y}), 32'(11'b00000_000_000));
    chk("rst_def", 32'({d_de, d_hs, d_vs, d_ls, d_fs, d_x, d_y}), 32'({5'b01100, 23'd0}));
    rst = 1'b0;
    for (int k = 0; k < 49; k++) begin
      step();
      eh  = 3'(k % 8);
      ev  = 3'((k / 8) % 6);
      ede = eh < 3'd4 && ev < 3'd3;
      ehs = !(eh == 3'd5 || eh == 3'd6);
      evs = ev != 3'd4;
      els = eh == 3'd0;
      efs = els && ev == 3'd0;
      chk("sml_frame", 32'({s_de, s_hs, s_vs, s_ls, s_fs, s_x, s_y}), 32'({ede, ehs, evs, els, efs, eh, ev}));
      chk("pos_frame", 32'({p_de, p_hs, p_vs, p_ls, p_fs, p_x, p_y}), 32'({ede, ~ehs, ~evs, els, efs, eh, ev}));
      if (!ede) chk("blank_token", 32'(tmds_ctrl(s_vs, s_hs)), 32'(tok(evs, ehs)));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("en_x0", 32'({s_x, s_de, s_fs}), 32'({3'd0, 1'b1, 1'b1}));
    step();
    chk("en_x1", 32'({s_x, s_de, s_ls}), 32'({3'd1, 1'b1, 1'b0}));
    en = 1'b0;
    step();
    chk("hold_a", 32'({s_x, s_y, s_de, s_ls, s_fs}), 32'({3'd1, 3'd0, 3'b100}));
    step();
    chk("hold_b", 32'({s_x, s_y, s_de, s_ls, s_fs}), 32'({3'd1, 3'd0, 3'b100}));
    en = 1'b1;
    step();
    chk("en_x2", 32'({s_x, s_y, s_de}), 32'({3'd2, 3'd0, 1'b1}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("pre_rst_pos", 32'({s_x, s_y, s_de}), 32'({3'd3, 3'd2, 1'b1}));
    rst = 1'b1;
    step();
    chk("mid_rst", 32'({s_de, s_hs, s_vs, s_ls, s_fs, s_x, s_y}), 32'(11'b01100_000_000));
    rst = 1'b0;
    step();
    chk("post_rst", 32'({s_de, s_hs, s_vs, s_ls, s_fs, s_x, s_y}), 32'(11'b11111_000_000));
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_de = 0;
    n_hl = 0;
    n_ls = 0;
    n_fs = 0;
    first_hl = -1;
    for (int k = 0; k < 800; k++) begin
      step();
      n_de += int'(d_de);
      n_ls += int'(d_ls);
      n_fs += int'(d_fs);
      if (!d_hs) begin
        n_hl++;
        if (first_hl < 0) first_hl = int'(d_x);
      end
    end
    chk("def_de_count", 32'(n_de), 32'd640);
    chk("def_hs_low_count", 32'(n_hl), 32'd96);
    chk("def_hs_first_low", 32'(first_hl), 32'd656);
    chk("def_strobes", 32'({n_ls[7:0], n_fs[7:0]}), 32'({8'd1, 8'd1}));
    chk("def_last", 32'({d_x, d_y, d_de, d_vs}), 32'({12'd799, 11'd0, 1'b0, 1'b1}));
    step();
    chk("def_line1", 32'({d_x, d_y, d_de, d_ls, d_fs}), 32'({12'd0, 11'd1, 3'b110}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
